serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial subtractor. Computes `a - b - bin` over WIDTH clock cycles using one full-subtractor cell and a borrow flip-flop, with a start/busy/done handshake. It is the inverse-operation counterpart to the team's combinational parallel adder: it trades area for latency and gives a sequential datapath block for the arithmetic library.

## Interface
- `WIDTH`, default 4: operand and result width in bits (≥2).
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `start`  in  1: request; sampled only when the block is ready.
- `a`  in  WIDTH: minuend, captured on the accepted start.
- `b`  in  WIDTH: subtrahend, captured on the accepted start.
- `bin`  in  1: borrow-in, captured on the accepted start.
- `busy`  out  1: high while an operation is in SHIFT.
- `done`  out  1: one-cycle pulse; `diff`/`bout` are valid from this cycle.
- `diff`  out  WIDTH: result `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1: borrow-out; 1 when `a < b + bin` (unsigned).

## Operation
- States:
  - IDLE: ready.
  - SHIFT: processing bits.
  - DONE: result presented.
- Reset (`reset_n`=0 at an edge):
  - state → IDLE.
  - `busy`=0, `done`=0, `diff`=0, `bout`=0, internal shift registers, bit counter and borrow FF cleared.
  - Reset takes effect mid-operation; the partial result is discarded.
- IDLE→SHIFT when `start`=1:
  - Load `a`, `b` into right-shift registers.
  - Borrow FF ← `bin`; counter ← 0.
- SHIFT, per edge, LSB first:
  - `d = a0 ^ b0 ^ br`
  - `br' = (~a0 & b0) | (~(a0 ^ b0) & br)`
  - `d` is shifted into the MSB of the internal result register.
  - Operand registers shift right; counter increments.
  - After the WIDTH-th bit: state → DONE, `diff` ← result register, `bout` ← final borrow.
- DONE → IDLE, or → SHIFT if `start`=1 in DONE (back-to-back, operands loaded as in IDLE).
- `start` while in SHIFT is ignored. There is no queueing and no effect on the operation in progress.
- `diff`/`bout` change only on the SHIFT→DONE edge and on reset. They hold through IDLE and through any subsequent SHIFT.
- Counter width is `$clog2(WIDTH+1)`; no wrap occurs within an operation.

## Timing
- Start accepted at edge k: `busy`=1 from edge k through edge k+WIDTH (exclusive). That is WIDTH cycles.
- Edge k+WIDTH: `busy`=0, `done`=1, `diff`/`bout` valid. Latency is WIDTH cycles from the accepting edge.
- Edge k+WIDTH+1: `done`=0.
- `done` is never high for two consecutive cycles.
- `busy` and `done` are never high together.
- Maximum throughput: one result per WIDTH+1 cycles (start held high continuously).
- Inputs `a`, `b`, `bin` are don't-care except at the accepting edge.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - Adds output port `ovf` (out, 1), a registered signed-overflow flag.
  - `ovf` = borrow into MSB XOR borrow out of MSB, evaluated at the MSB step.
  - `ovf` updates with `diff` at the SHIFT→DONE edge and resets to 0.
- Undefined: no `ovf` port and no overflow logic; all other behaviour is identical.

## Test plan
- WIDTH=4, reset held 2 cycles, then released:
  - All outputs 0.
  - `start`=0 for 3 cycles → stays IDLE with `busy`=0, `done`=0.
- `a`=5, `b`=2, `bin`=0, start pulse:
  - `busy` high exactly 4 cycles.
  - `done` pulses on the 4th edge after acceptance with `diff`=3, `bout`=0.
  - Repeat with `bin`=1 → `diff`=2.
- `a`=2, `b`=5, `bin`=0 → `diff`=13, `bout`=1.
- `a`=0, `b`=0, `bin`=1 → `diff`=15, `bout`=1.
- Start 5−2 with `start` held high throughout, operands changed to 9−4 after the accepting edge:
  - First result 3; new start accepted in the DONE cycle.
  - Second result 5, 5 cycles after the first `done`.
  - `start` pulses while `busy` have no effect.
- Reset during the 2nd SHIFT cycle of 7−1:
  - Next cycle `busy`=0, `diff`=0, no `done`.
  - A fresh 7−1 then yields 6.
- With `SERIAL_SUB_OVF_EN`:
  - 8−1 → `diff`=7, `ovf`=1.
  - 7−15 → `diff`=8, `ovf`=1.
  - 5−2 → `ovf`=0.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor: start/busy/done handshake plus data.
// With SERIAL_SUB_OVF_EN defined the bundle also carries the signed-overflow flag ovf.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
`else
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin over WIDTH cycles, LSB first, one full-subtractor cell and a borrow FF.
// Optional feature: define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    serial_subtractor_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             accept;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_n;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;

    logic             cell_d;
    logic             cell_br;

    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    // Returns {borrow_out, difference} for one bit position.
    function automatic logic [1:0] full_sub(input logic a0, input logic b0, input logic bi);
        logic d;
        logic bo;
        d  = a0 ^ b0 ^ bi;
        bo = (~a0 & b0) | (~(a0 ^ b0) & bi);
        return {bo, d};
    endfunction

    assign {cell_br, cell_d} = full_sub(a_sh[0], b_sh[0], br);
    assign last_bit          = (cnt == CNT_W'(WIDTH - 1));
    assign res_n             = (res_sh >> 1) | {cell_d, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                // Back-to-back start is taken straight from the result cycle.
                if (bus.start) begin
                    accept  = 1'b1;
                    state_n = SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_sh   <= bus.a;
                b_sh   <= bus.b;
                res_sh <= '0;
                br     <= bus.bin;
                cnt    <= '0;
            end else if (state == SHIFT) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                res_sh <= res_n;
                br     <= cell_br;
                cnt    <= cnt + CNT_W'(1);
            end

            // Results move only on the final bit; they hold through IDLE and later SHIFTs.
            if ((state == SHIFT) && last_bit) begin
                diff_q <= res_n;
                bout_q <= cell_br;
`ifdef SERIAL_SUB_OVF_EN
                ovf_q  <= br ^ cell_br;
`endif
            end
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, hand-written corner sequences
// and random operations checked against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;
    logic prev_done;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and two's-complement views.
    task automatic ref_sub(input int av, input int bv, input int bi,
                           output logic [W-1:0] d, output logic bo, output logic ov);
        int r;
        int sa;
        int sb;
        int sr;
        r  = av - bv - bi;
        d  = W'(r + (1 << W));
        bo = (av < bv + bi);
        sa = (av >= (1 << (W-1))) ? av - (1 << W) : av;
        sb = (bv >= (1 << (W-1))) ? bv - (1 << W) : bv;
        sr = sa - sb - bi;
        ov = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
    endtask

    // One operation from IDLE: check busy window, latency, result and done pulse width.
    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic bi, input logic [W-1:0] ed, input logic ebo, input logic eov);
        int lat;
        int busy_cnt;
        @(negedge clock);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.bin   = bi;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom_range(0, (1 << W) - 1);
        bus.b     = $urandom_range(0, (1 << W) - 1);
        bus.bin   = 1'($urandom_range(0, 1));
        lat       = 0;
        busy_cnt  = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_cnt++;
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, W);
        check({tag, " busy cycles"}, busy_cnt, W);
        check({tag, " diff"}, int'(bus.diff), int'(ed));
        check({tag, " bout"}, int'(bus.bout), int'(ebo));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, " ovf"}, int'(bus.ovf), int'(eov));
`else
        if (eov === 1'bx) $display("unexpected X in ovf expectation");
`endif
        @(posedge clock);
        #1;
        check({tag, " done drops"}, int'(bus.done), 0);
        check({tag, " diff holds"}, int'(bus.diff), int'(ed));
    endtask

    // Handshake invariants watched on every cycle outside reset.
    always @(negedge clock) begin
        if (reset_n) begin
            checks++;
            if (bus.busy && bus.done) begin
                errors++;
                $display("FAIL busy_and_done: busy=%0d done=%0d, required not both 1", bus.busy, bus.done);
            end
            checks++;
            if (bus.done && prev_done) begin
                errors++;
                $display("FAIL done_width: done=%0d for two cycles, required single-cycle pulse", bus.done);
            end
        end
        prev_done = bus.done;
    end

    initial begin
        logic [W-1:0] ed;
        logic         ebo;
        logic         eov;
        int           lat;

        checks    = 0;
        errors    = 0;
        prev_done = 1'b0;

        vecs[0] = '{a: 4'd5,  b: 4'd2,  bin: 1'b0, d: 4'd3,  bo: 1'b0, ov: 1'b0};
        vecs[1] = '{a: 4'd5,  b: 4'd2,  bin: 1'b1, d: 4'd2,  bo: 1'b0, ov: 1'b0};
        vecs[2] = '{a: 4'd2,  b: 4'd5,  bin: 1'b0, d: 4'd13, bo: 1'b1, ov: 1'b0};
        vecs[3] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, d: 4'd15, bo: 1'b1, ov: 1'b0};
        vecs[4] = '{a: 4'd8,  b: 4'd1,  bin: 1'b0, d: 4'd7,  bo: 1'b0, ov: 1'b1};
        vecs[5] = '{a: 4'd7,  b: 4'd15, bin: 1'b0, d: 4'd8,  bo: 1'b1, ov: 1'b1};
        vecs[6] = '{a: 4'd15, b: 4'd15, bin: 1'b1, d: 4'd15, bo: 1'b1, ov: 1'b0};
        vecs[7] = '{a: 4'd0,  b: 4'd15, bin: 1'b0, d: 4'd1,  bo: 1'b1, ov: 1'b0};

        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset diff", int'(bus.diff), 0);
        check("reset bout", int'(bus.bout), 0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset ovf", int'(bus.ovf), 0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("idle busy", int'(bus.busy), 0);
            check("idle done", int'(bus.done), 0);
        end

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                  vecs[i].d, vecs[i].bo, vecs[i].ov);
        end

        // Start held high: 5-2 then 9-4 accepted in the DONE cycle.
        @(negedge clock);
        bus.start = 1'b1;
        bus.a     = 4'd5;
        bus.b     = 4'd2;
        bus.bin   = 1'b0;
        @(posedge clock);
        #1;
        bus.a = 4'd9;
        bus.b = 4'd4;
        lat   = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("b2b first latency", lat, W);
        check("b2b first diff", int'(bus.diff), 3);
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
            if (lat == 1) check("b2b reaccept busy", int'(bus.busy), 1);
        end while (!bus.done && lat < 20);
        bus.start = 1'b0;
        check("b2b spacing", lat, W + 1);
        check("b2b second diff", int'(bus.diff), 5);
        check("b2b second bout", int'(bus.bout), 0);
        @(posedge clock);
        #1;
        check("b2b idle busy", int'(bus.busy), 0);
        check("b2b idle done", int'(bus.done), 0);

        // A start pulse during SHIFT must not disturb the operation in progress.
        @(negedge clock);
        bus.start = 1'b1;
        bus.a     = 4'd7;
        bus.b     = 4'd1;
        bus.bin   = 1'b0;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        @(negedge clock);
        bus.start = 1'b1;
        bus.a     = 4'd0;
        bus.b     = 4'd1;
        bus.bin   = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        lat       = 1;
        while (!bus.done && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("ignore latency", lat, W);
        check("ignore diff", int'(bus.diff), 6);
        check("ignore bout", int'(bus.bout), 0);
        @(posedge clock);
        #1;
        check("ignore no restart", int'(bus.busy), 0);

        // Reset in the second SHIFT cycle discards the partial result.
        @(negedge clock);
        bus.start = 1'b1;
        bus.a     = 4'd7;
        bus.b     = 4'd1;
        bus.bin   = 1'b0;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("midrst busy", int'(bus.busy), 0);
        check("midrst done", int'(bus.done), 0);
        check("midrst diff", int'(bus.diff), 0);
        check("midrst bout", int'(bus.bout), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("midrst no done", int'(bus.done), 0);
        do_op("after reset", 4'd7, 4'd1, 1'b0, 4'd6, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rbi;
            ra  = W'($urandom_range(0, (1 << W) - 1));
            rb  = W'($urandom_range(0, (1 << W) - 1));
            rbi = 1'($urandom_range(0, 1));
            ref_sub(int'(ra), int'(rb), int'(rbi), ed, ebo, eov);
            do_op($sformatf("rand%0d %0d-%0d-%0d", i, ra, rb, rbi), ra, rb, rbi, ed, ebo, eov);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
